vigenere_cipher_stream: RTL and testbench

VIGENERE_CIPHER_STREAM -- requirements
Module: vigenere_cipher_stream

---
 rtl/vigenere_cipher_stream.sv | 88 ++++++++
 tb/tb_vigenere_cipher_stream.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vigenere_cipher_stream.sv
// vigenere_cipher_stream: streaming Vigenere cipher over ASCII bytes with a programmable key.
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   key_we/key_addr/key_data write one key shift entry (0..25, 26..31 folded down)
//   len_we/len_data          write the active key length (clamped to 1..KEY_LEN)
//   mode                     0 = encrypt, 1 = decrypt, sampled per accepted beat
//   s_valid/s_ready/s_data/s_last  input byte stream
//   m_valid/m_ready/m_data/m_last  output byte stream, one registered stage
module vigenere_cipher_stream #(
    parameter int KEY_LEN       = 8,
    parameter int DEFAULT_SHIFT = 3,
    localparam int AW           = $clog2(KEY_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [AW-1:0] key_addr,
    input  logic [4:0]    key_data,
    input  logic          len_we,
    input  logic [AW:0]   len_data,
    input  logic          mode,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [7:0]    m_data,
    output logic          m_last
);
    localparam logic [4:0]  DEF = 5'(DEFAULT_SHIFT);
    localparam logic [AW:0] KL  = (AW + 1)'(KEY_LEN);

    logic [4:0]    key [KEY_LEN];
    logic [AW:0]   klen;
    logic [AW-1:0] pos;
    logic [4:0]    k, sh, off, rot;
    logic [5:0]    sum;
    logic [7:0]    base, enc;
    logic          upper, lower, letter, in_xfer, pos_end;

    assign s_ready = !m_valid || m_ready;
    assign in_xfer = s_valid && s_ready;

    // Decrypt shifts by the additive inverse so one adder serves both modes.
    always_comb begin
        k       = key[pos];
        sh      = mode ? (k == 5'd0 ? 5'd0 : 5'd26 - k) : k;
        upper   = s_data >= 8'h41 && s_data <= 8'h5a;
        lower   = s_data >= 8'h61 && s_data <= 8'h7a;
        letter  = upper || lower;
        base    = upper ? 8'h41 : 8'h61;
        off     = 5'(s_data - base);
        sum     = {1'b0, off} + {1'b0, sh};
        rot     = sum >= 6'd26 ? 5'(sum - 6'd26) : sum[4:0];
        enc     = letter ? base + {3'b000, rot} : s_data;
        pos_end = ({1'b0, pos} + (AW + 1)'(1)) == klen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
        end else if (in_xfer) begin
            m_valid <= 1'b1;
            m_data  <= enc;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Configuration writes restart the key and win over any same-cycle advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_LEN; i++) key[i] <= DEF;
            klen <= (AW + 1)'(1);
            pos  <= '0;
        end else begin
            if (key_we) key[key_addr] <= key_data >= 5'd26 ? key_data - 5'd26 : key_data;
            if (len_we) klen <= len_data == '0 ? (AW + 1)'(1) : (len_data > KL ? KL : len_data);
            if (key_we || len_we) pos <= '0;
            else if (in_xfer && s_last) pos <= '0;
            else if (in_xfer && letter) pos <= pos_end ? '0 : pos + AW'(1);
        end
    end
endmodule

// File: tb/tb_vigenere_cipher_stream.sv
// tb_vigenere_cipher_stream: directed and randomized checks against a queue-based reference model.
module tb_vigenere_cipher_stream;
    logic       clk = 0, rst = 0;
    logic       key_we = 0, len_we = 0, mode = 0;
    logic [2:0] key_addr = 0;
    logic [4:0] key_data = 0;
    logic [3:0] len_data = 0;
    logic       s_valid = 0, s_last = 0, m_ready = 0;
    logic [7:0] s_data = 0;
    logic       s_ready, m_valid, m_last;
    logic [7:0] m_data;

    int n_vec = 0, n_err = 0;
    int mkey [8];
    int mklen, mpos;
    logic [8:0] q [$];
    logic [7:0] got_q [$];
    int n_last, last_at;

    vigenere_cipher_stream dut (
        .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
        .len_we(len_we), .len_data(len_data), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_char(logic [7:0] c, int kk, logic md);
        int ci = int'(c);
        int s = md ? (26 - kk) % 26 : kk;
        if (ci >= 65 && ci <= 90) return 8'(65 + (ci - 65 + s) % 26);
        if (ci >= 97 && ci <= 122) return 8'(97 + (ci - 97 + s) % 26);
        return c;
    endfunction

    function automatic bit is_letter(logic [7:0] c);
        return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 8; i++) mkey[i] = 3;
        mklen = 1;
        mpos = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit exp_mv, exp_sr, do_in, do_out;
        @(negedge clk);
        exp_mv = q.size() != 0;
        exp_sr = !exp_mv || m_ready;
        chk("m_valid", m_valid, exp_mv);
        chk("s_ready", s_ready, exp_sr);
        if (exp_mv) begin
            chk("m_data", m_data, q[0][7:0]);
            chk("m_last", m_last, q[0][8]);
        end
        do_in = s_valid && exp_sr;
        do_out = exp_mv && m_ready;
        if (do_out) begin
            got_q.push_back(m_data);
            if (m_last) begin
                n_last++;
                last_at = got_q.size() - 1;
            end
            void'(q.pop_front());
        end
        if (do_in) begin
            q.push_back({s_last, ref_char(s_data, mkey[mpos], mode)});
            if (s_last) mpos = 0;
            else if (is_letter(s_data)) mpos = (mpos + 1) % mklen;
        end
        if (key_we) mkey[key_addr] = key_data >= 26 ? key_data - 26 : key_data;
        if (len_we) mklen = len_data == 0 ? 1 : (len_data > 8 ? 8 : len_data);
        if (key_we || len_we) mpos = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wcfg(logic kwe, logic [2:0] ka, logic [4:0] kd, logic lwe, logic [3:0] ld);
        s_valid = 0; m_ready = 1;
        key_we = kwe; key_addr = ka; key_data = kd; len_we = lwe; len_data = ld;
        tick();
        key_we = 0; len_we = 0;
    endtask

    task automatic send_msg(string str, logic md, string exp);
        got_q.delete(); n_last = 0; last_at = -1;
        for (int i = 0; i < str.len(); i++) begin
            s_valid = 1; s_data = str[i]; s_last = (i == str.len() - 1); mode = md; m_ready = 1;
            tick();
        end
        s_valid = 0; s_last = 0;
        tick();
        chk("msg_len", got_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < got_q.size(); i++) chk("msg_char", got_q[i], exp[i]);
        chk("last_cnt", n_last, 1);
        chk("last_at", last_at, exp.len() - 1);
    endtask

    initial begin
        model_reset();
        #1 rst = 1;
        #3;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk); #1 rst = 0;
        send_msg("Hello xyz!", 0, "Khoor abc!");
        wcfg(1, 0, 10, 0, 0);
        wcfg(1, 1, 4, 0, 0);
        wcfg(1, 2, 24, 1, 3);
        send_msg("ATTACK AT DAWN", 0, "KXRKGI KX BKAL");
        send_msg("KXRKGI KX BKAL", 1, "ATTACK AT DAWN");
        send_msg("AB", 0, "KF");
        send_msg("A", 0, "K");
        // Stall: continuous input with the sink blocked for three cycles.
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 8'(97 + i); s_last = 0; mode = 0; m_ready = 0;
            tick();
        end
        chk("stall_s_ready", s_ready, 0);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1; s_data = 8'(100 + i); s_last = (i == 3); m_ready = 1;
            tick();
        end
        s_valid = 0; s_last = 0;
        tick();
        chk("stall_beats", got_q.size(), 5);
        // Folded key value and zero length, then reset mid-message.
        wcfg(1, 0, 29, 1, 0);
        send_msg("a", 0, "d");
        wcfg(1, 0, 10, 1, 2);
        s_valid = 1; s_data = "b"; s_last = 0; mode = 0; m_ready = 0;
        tick();
        s_valid = 0;
        tick();
        #2 rst = 1;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_s_ready", s_ready, 1);
        model_reset();
        @(posedge clk); #1 rst = 0;
        m_ready = 1;
        got_q.delete();
        tick();
        chk("no_stale_beat", got_q.size(), 0);
        send_msg("a", 0, "d");
        // Randomized traffic with interleaved configuration writes.
        for (int n = 0; n < 2000; n++) begin
            int r = $urandom_range(0, 3);
            s_valid = $urandom_range(0, 3) != 0;
            s_data = r == 0 ? 8'(65 + $urandom_range(0, 25)) :
                     r == 1 ? 8'(97 + $urandom_range(0, 25)) : 8'($urandom);
            s_last = $urandom_range(0, 7) == 0;
            mode = 1'($urandom);
            m_ready = $urandom_range(0, 3) != 0;
            key_we = $urandom_range(0, 19) == 0;
            key_addr = 3'($urandom);
            key_data = 5'($urandom);
            len_we = $urandom_range(0, 29) == 0;
            len_data = 4'($urandom);
            tick();
        end
        key_we = 0; len_we = 0; s_valid = 0; m_ready = 1;
        tick();
        chk("drained", m_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
